// File: rtl/zkrom_arbiter_pkg.sv
// rtl/zkrom_arbiter_pkg.sv - shared constants and types for the ZkROM glyph arbiter
package zkrom_arbiter_pkg;

    localparam int ZK_GLYPH_W = 5;
    localparam int ZK_ROW_W   = 4;
    localparam int ZK_ADDR_W  = ZK_GLYPH_W + ZK_ROW_W;
    localparam int ZK_DATA_W  = 8;

    localparam logic [ZK_GLYPH_W-1:0] GLYPH_DIGIT_0 = 5'd0;
    localparam logic [ZK_GLYPH_W-1:0] GLYPH_DIGIT_1 = 5'd1;
    localparam logic [ZK_GLYPH_W-1:0] GLYPH_DIGIT_2 = 5'd2;
    localparam logic [ZK_GLYPH_W-1:0] GLYPH_DIGIT_3 = 5'd3;
    localparam logic [ZK_GLYPH_W-1:0] GLYPH_BLANK   = 5'd19;

    // Which path produced this cycle's grant; only round-robin grants advance the pointer.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RR   = 2'd1,
        SEL_PRIO = 2'd2
    } sel_src_e;

    function automatic logic [ZK_ADDR_W-1:0] zk_addr(
        input logic [ZK_GLYPH_W-1:0] glyph,
        input logic [ZK_ROW_W-1:0]   row
    );
        return {glyph, row};
    endfunction

endpackage

// File: rtl/zkrom_arbiter_rr.sv
// rtl/zkrom_arbiter_rr.sv - one-hot round-robin picker searching upward from a pointer with wrap
module zkrom_arbiter_rr #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/zkrom_arbiter.sv
// rtl/zkrom_arbiter.sv - shares one synchronous glyph ROM among requesters with tagged fixed-latency returns
module zkrom_arbiter
    import zkrom_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = ZK_ADDR_W,
    parameter int DATA_W   = ZK_DATA_W,
    parameter int ROM_LAT  = 1,
    parameter int PRIO_REQ = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_dout
);

    localparam int                 IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam bit                 PRIO_EN  = (PRIO_REQ < NUM_REQ);
    localparam logic [IDX_W-1:0]   PRIO_IDX = IDX_W'(PRIO_EN ? PRIO_REQ : 0);
    localparam logic [NUM_REQ-1:0] PRIO_OH  = PRIO_EN ? (NUM_REQ'(1) << PRIO_REQ) : '0;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("zkrom_arbiter: NUM_REQ out of range 2..8");
        end
        if (PRIO_REQ < 0 || PRIO_REQ > NUM_REQ) begin : g_bad_prio_req
            $error("zkrom_arbiter: PRIO_REQ out of range 0..NUM_REQ");
        end
        if (ROM_LAT < 0) begin : g_bad_rom_lat
            $error("zkrom_arbiter: ROM_LAT must be non-negative");
        end
    endgenerate

    logic [IDX_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [NUM_REQ-1:0] r_tag [ROM_LAT+1];
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;

    logic               w_prio_hit;
    logic [NUM_REQ-1:0] w_rr_gnt;
    logic [IDX_W-1:0]   w_rr_idx;
    logic               w_rr_any;
    sel_src_e           w_src;
    logic [NUM_REQ-1:0] w_sel_gnt;
    logic [IDX_W-1:0]   w_win;
    logic [ADDR_W-1:0]  w_addr;
    logic [IDX_W-1:0]   w_ptr_nxt;

    generate
        if (PRIO_EN) begin : g_prio
            assign w_prio_hit = req[PRIO_REQ];
        end else begin : g_no_prio
            assign w_prio_hit = 1'b0;
        end
    endgenerate

    zkrom_arbiter_rr #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx),
        .o_any (w_rr_any)
    );

    // The live pixel path overrides round-robin without disturbing its fairness state.
    always_comb begin
        w_src     = SEL_NONE;
        w_sel_gnt = '0;
        w_win     = '0;
        if (w_prio_hit) begin
            w_src     = SEL_PRIO;
            w_sel_gnt = PRIO_OH;
            w_win     = PRIO_IDX;
        end else if (w_rr_any) begin
            w_src     = SEL_RR;
            w_sel_gnt = w_rr_gnt;
            w_win     = w_rr_idx;
        end
    end

    assign gnt       = rst_n ? w_sel_gnt : '0;
    assign w_addr    = req_addr[int'(w_win)*ADDR_W +: ADDR_W];
    assign w_ptr_nxt = (w_rr_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_rr_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_rom_addr  <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (w_src != SEL_NONE) begin
                r_rom_addr <= w_addr;
            end
            if (w_src == SEL_RR) begin
                r_ptr <= w_ptr_nxt;
            end
            r_tag[0] <= w_sel_gnt;
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            // Tag reaches the end of the pipe exactly when rom_dout holds that lookup's row.
            r_rsp_valid <= r_tag[ROM_LAT];
            if (|r_tag[ROM_LAT]) begin
                r_rsp_data <= rom_dout;
            end
        end
    end

    assign rom_addr  = r_rom_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_zkrom_arbiter.sv
// tb/tb_zkrom_arbiter.sv - self-checking bench for zkrom_arbiter with and without a priority port
module tb_zkrom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req0, req1, gnt0, gnt1, rv0, rv1;
    logic [35:0] addr0, addr1;
    logic [7:0]  rd0, rd1, dout0, dout1;
    logic [8:0]  ra0, ra1;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] RR_TAB   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    localparam logic [8:0] B2B_ADDR [5] = '{9'h010, 9'h021, 9'h032, 9'h043, 9'h1F4};
    localparam logic [7:0] B2B_DATA [5] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h4E};

    always #5 clk = ~clk;

    zkrom_arbiter #(.PRIO_REQ(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .req_addr(addr0), .gnt(gnt0),
        .rsp_valid(rv0), .rsp_data(rd0), .rom_addr(ra0), .rom_dout(dout0)
    );

    zkrom_arbiter #(.PRIO_REQ(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .req_addr(addr1), .gnt(gnt1),
        .rsp_valid(rv1), .rsp_data(rd1), .rom_addr(ra1), .rom_dout(dout1)
    );

    function automatic logic [7:0] rom_fn(input logic [8:0] a);
        return {a[3:0], a[7:4]} ^ {7'b0, a[8]};
    endfunction

    always @(posedge clk) begin
        dout0 <= rom_fn(ra0);
        dout1 <= rom_fn(ra1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    int         m_ptr [2];
    logic [8:0] m_ra  [2];
    logic [7:0] m_rd  [2];
    logic [3:0] m_sv  [2][8];
    logic [7:0] m_sd  [2][8];
    int         m_n;

    task automatic model_cycle(input int k, input logic [3:0] rq, input logic [35:0] ad,
                               input logic [3:0] g, input logic [3:0] rv,
                               input logic [7:0] rd, input logic [8:0] ra);
        int         prio;
        int         win;
        int         slot;
        bit         by_prio;
        logic [3:0] eg;
        prio    = (k == 0) ? 0 : 4;
        slot    = m_n % 8;
        win     = -1;
        by_prio = 1'b0;
        eg      = '0;
        if (prio < 4 && rq[prio]) begin
            win     = prio;
            by_prio = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (win < 0 && rq[(m_ptr[k] + i) % 4]) win = (m_ptr[k] + i) % 4;
            end
        end
        if (win >= 0) eg[win] = 1'b1;
        chk($sformatf("gnt%0d", k), 32'(g), 32'(eg));
        chk($sformatf("rsp_valid%0d", k), 32'(rv), 32'(m_sv[k][slot]));
        if (m_sv[k][slot] != 0) m_rd[k] = m_sd[k][slot];
        chk($sformatf("rsp_data%0d", k), 32'(rd), 32'(m_rd[k]));
        chk($sformatf("rom_addr%0d", k), 32'(ra), 32'(m_ra[k]));
        m_sv[k][slot] = '0;
        if (win >= 0) begin
            m_ra[k] = ad[win*9 +: 9];
            m_sv[k][(m_n + 3) % 8] = eg;
            m_sd[k][(m_n + 3) % 8] = rom_fn(m_ra[k]);
            if (!by_prio) m_ptr[k] = (win + 1) % 4;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_gnt0", 32'(gnt0), 0);
                chk("rst_gnt1", 32'(gnt1), 0);
                chk("rst_rv0", 32'(rv0), 0);
                chk("rst_rv1", 32'(rv1), 0);
                chk("rst_ra0", 32'(ra0), 0);
                chk("rst_ra1", 32'(ra1), 0);
                for (int k = 0; k < 2; k++) begin
                    m_ptr[k] = 0;
                    m_ra[k]  = '0;
                    m_rd[k]  = '0;
                    for (int s = 0; s < 8; s++) begin
                        m_sv[k][s] = '0;
                        m_sd[k][s] = '0;
                    end
                end
                m_n = 0;
            end else begin
                model_cycle(0, req0, addr0, gnt0, rv0, rd0, ra0);
                model_cycle(1, req1, addr1, gnt1, rv1, rd1, ra1);
                m_n++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0  = 4'b1111;
        addr0 = {9'h004, 9'h003, 9'h002, 9'h001};
        req1  = 4'b0000;
        addr1 = '0;
        step();
        step();
        peek();
        chk("lit_rst_gnt", 32'(gnt0), 32'h0);
        chk("lit_rst_rv", 32'(rv0), 32'h0);
        chk("lit_rst_ra", 32'(ra0), 32'h0);
        step();
        rst_n = 1'b1;
        peek();
        chk("lit_first_gnt", 32'(gnt0), 32'b0001);
        step();
        req0 = 4'b0000;

        addr1 = {9'h140, 9'h130, 9'h120, 9'h110};
        req1  = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            peek();
            chk("lit_rr_gnt", 32'(gnt1), 32'(RR_TAB[i % 4]));
            if (i >= 3) chk("lit_rr_rv", 32'(rv1), 32'(RR_TAB[(i - 3) % 4]));
            step();
        end
        req1 = 4'b0000;
        repeat (4) step();

        addr1[2*9 +: 9] = 9'h063;
        req1 = 4'b0100;
        peek();
        chk("lit_lat_gnt", 32'(gnt1), 32'b0100);
        step();
        req1 = 4'b0000;
        peek();
        chk("lit_lat_rom_addr", 32'(ra1), 32'h063);
        step();
        step();
        peek();
        chk("lit_lat_rv", 32'(rv1), 32'b0100);
        chk("lit_lat_data", 32'(rd1), 32'h36);
        step();

        addr0 = {9'h0F3, 9'h0E2, 9'h0D1, 9'h0C0};
        req0  = 4'b1110;
        peek();
        chk("lit_prio_rr1", 32'(gnt0), 32'b0010);
        step();
        req0 = 4'b1111;
        repeat (3) begin
            peek();
            chk("lit_prio_hit", 32'(gnt0), 32'b0001);
            step();
        end
        req0 = 4'b1110;
        peek();
        chk("lit_prio_resume", 32'(gnt0), 32'b0100);
        step();
        req0 = 4'b0000;
        repeat (4) step();

        for (int i = 0; i < 9; i++) begin
            if (i < 5) begin
                req1 = 4'b0010;
                addr1[9 +: 9] = B2B_ADDR[i];
            end else begin
                req1 = 4'b0000;
            end
            peek();
            if (i < 5) chk("lit_b2b_gnt", 32'(gnt1), 32'b0010);
            if (i >= 3 && i < 8) begin
                chk("lit_b2b_rv", 32'(rv1), 32'b0010);
                chk("lit_b2b_data", 32'(rd1), 32'(B2B_DATA[i - 3]));
            end
            if (i == 8) chk("lit_b2b_end", 32'(rv1), 32'b0000);
            step();
        end
        repeat (2) step();

        addr1[0 +: 9] = 9'h0AB;
        req1 = 4'b0001;
        peek();
        chk("lit_mid_gnt", 32'(gnt1), 32'b0001);
        step();
        req1  = 4'b0000;
        rst_n = 1'b0;
        peek();
        chk("lit_mid_rv_rst", 32'(rv1), 32'b0000);
        step();
        rst_n = 1'b1;
        repeat (5) begin
            peek();
            chk("lit_mid_rv_after", 32'(rv1), 32'b0000);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
